// File: rtl/cfg_ctx_out_pea_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cfg_ctx_out_pea_seq_pkg
// Brief   : Shared sizes, sequencer state type and context selector type for
//           the multi-context PEA output-selector configuration block.
// Revision: 1.0 - initial release
// ============================================================================
package cfg_ctx_out_pea_seq_pkg;

    // Crossbar geometry: M legal sources, LOG_M bits per selector
    localparam int M         = 6;
    localparam int LOG_M     = 3;

    // PEA geometry
    localparam int N_OUT_PEA = 4;
    localparam int KMEM_SIZE = 4;
    localparam int N_CFG_REGS_SEL_OUT_PEA = (N_OUT_PEA * KMEM_SIZE * LOG_M + 31) / 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } out_seq_state_e;

    typedef logic [N_OUT_PEA-1:0][LOG_M-1:0] out_sel_ctx_t;

    // Width of a context index; a single context still needs one bit
    function automatic int ctx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_ctx_out_pea_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : cfg_ctx_out_pea_seq_if
// Brief   : Config/control bundle between PEA controller, config register file
//           and the output-selector sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface cfg_ctx_out_pea_seq_if #(
    parameter int N_OUT       = cfg_ctx_out_pea_seq_pkg::N_OUT_PEA,
    parameter int LOG_M       = cfg_ctx_out_pea_seq_pkg::LOG_M,
    parameter int N_CTX       = cfg_ctx_out_pea_seq_pkg::KMEM_SIZE,
    parameter int N_CFG_WORDS = cfg_ctx_out_pea_seq_pkg::N_CFG_REGS_SEL_OUT_PEA
);
    localparam int CTX_W = cfg_ctx_out_pea_seq_pkg::ctx_width(N_CTX);

    logic [N_CFG_WORDS*32-1:0]    reg_cfg_sel_i;
    logic                         start_i;
    logic [CTX_W-1:0]             n_ctx_i;
    logic [15:0]                  n_iter_i;
    logic                         step_i;
    logic                         abort_i;
    logic [N_OUT-1:0][LOG_M-1:0]  sel_output_o;
    logic [CTX_W-1:0]             ctx_o;
    logic                         busy_o;
    logic                         done_o;
    logic                         cfg_err_o;

    modport master (
        output reg_cfg_sel_i, start_i, n_ctx_i, n_iter_i, step_i, abort_i,
        input  sel_output_o, ctx_o, busy_o, done_o, cfg_err_o
    );

    modport slave (
        input  reg_cfg_sel_i, start_i, n_ctx_i, n_iter_i, step_i, abort_i,
        output sel_output_o, ctx_o, busy_o, done_o, cfg_err_o
    );

endinterface
`default_nettype wire

// File: rtl/cfg_ctx_out_pea_unpack.sv
`default_nettype none
// ============================================================================
// Module  : cfg_ctx_out_pea_unpack
// Brief   : Combinational slicer from the flat config bus to per-context
//           selector words. MAGE_OUT_SEL_CHECK_EN zeroes illegal selectors
//           (>= N_SRC) and flags them on err.
// Revision: 1.0 - initial release
// ============================================================================
module cfg_ctx_out_pea_unpack #(
    parameter int N_OUT       = cfg_ctx_out_pea_seq_pkg::N_OUT_PEA,
    parameter int LOG_M       = cfg_ctx_out_pea_seq_pkg::LOG_M,
    parameter int N_CTX       = cfg_ctx_out_pea_seq_pkg::KMEM_SIZE,
    parameter int N_SRC       = cfg_ctx_out_pea_seq_pkg::M,
    parameter int N_CFG_WORDS = cfg_ctx_out_pea_seq_pkg::N_CFG_REGS_SEL_OUT_PEA
) (
    input  wire logic [N_CFG_WORDS*32-1:0]               reg_cfg_sel,
    output logic      [N_CTX-1:0][N_OUT-1:0][LOG_M-1:0]  ctx_sel,
    output logic                                         err
);
    localparam int N_BITS = N_CTX * N_OUT * LOG_M;

    logic [N_CTX*N_OUT-1:0] w_bad;

`ifdef MAGE_OUT_SEL_CHECK_EN
    localparam logic [LOG_M:0] c_n_src = (LOG_M+1)'(N_SRC);
`endif

    for (genvar c = 0; c < N_CTX; c++) begin : g_ctx
        for (genvar j = 0; j < N_OUT; j++) begin : g_out
            logic [LOG_M-1:0] w_raw;
            assign w_raw = reg_cfg_sel[((c*N_OUT+j+1)*LOG_M)-1 -: LOG_M];
`ifdef MAGE_OUT_SEL_CHECK_EN
            assign w_bad[c*N_OUT+j] = ({1'b0, w_raw} >= c_n_src);
            assign ctx_sel[c][j]    = w_bad[c*N_OUT+j] ? '0 : w_raw;
`else
            assign w_bad[c*N_OUT+j] = 1'b0;
            if (N_SRC > 0) begin : g_pass
                assign ctx_sel[c][j] = w_raw;
            end else begin : g_none
                assign ctx_sel[c][j] = '0;
            end
`endif
        end
    end

    assign err = |w_bad;

    // Padding bits above the last selector in the final config word
    if (N_CFG_WORDS*32 > N_BITS) begin : g_spare
        logic w_unused_pad;
        assign w_unused_pad = ^reg_cfg_sel[N_CFG_WORDS*32-1:N_BITS];
    end

endmodule
`default_nettype wire

// File: rtl/cfg_ctx_out_pea_seq.sv
`default_nettype none
// ============================================================================
// Module  : cfg_ctx_out_pea_seq
// Brief   : Snapshots all selector contexts on start, then steps through them
//           per PEA iteration driving registered crossbar selectors.
//           Optional MAGE_OUT_SEL_CHECK_EN enables illegal-selector checking.
// Revision: 1.0 - initial release
// ============================================================================
module cfg_ctx_out_pea_seq #(
    parameter int N_OUT       = cfg_ctx_out_pea_seq_pkg::N_OUT_PEA,
    parameter int LOG_M       = cfg_ctx_out_pea_seq_pkg::LOG_M,
    parameter int N_CTX       = cfg_ctx_out_pea_seq_pkg::KMEM_SIZE,
    parameter int N_SRC       = cfg_ctx_out_pea_seq_pkg::M,
    parameter int N_CFG_WORDS = cfg_ctx_out_pea_seq_pkg::N_CFG_REGS_SEL_OUT_PEA
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    cfg_ctx_out_pea_seq_if.slave io
);
    import cfg_ctx_out_pea_seq_pkg::*;

    localparam int CTX_W = ctx_width(N_CTX);
    localparam logic [CTX_W-1:0] c_ctx_max = CTX_W'(N_CTX - 1);

    typedef logic [N_OUT-1:0][LOG_M-1:0] sel_t;

    out_seq_state_e                 r_state, w_state_nxt;
    logic [N_CTX-1:0][N_OUT-1:0][LOG_M-1:0] r_shadow, w_shadow_nxt, w_unpacked;
    sel_t                           r_sel, w_sel_nxt;
    logic [CTX_W-1:0]               r_ctx, w_ctx_nxt, w_ctx_inc;
    logic [CTX_W-1:0]               r_n_ctx, w_n_ctx_nxt, w_n_ctx_clamped;
    logic [15:0]                    r_iter, w_iter_nxt, r_n_iter, w_n_iter_nxt;
    logic                           r_done, w_done_nxt;
    logic                           r_cfg_err, w_cfg_err_nxt, w_unpack_err;

    cfg_ctx_out_pea_unpack #(
        .N_OUT       (N_OUT),
        .LOG_M       (LOG_M),
        .N_CTX       (N_CTX),
        .N_SRC       (N_SRC),
        .N_CFG_WORDS (N_CFG_WORDS)
    ) u_unpack (
        .reg_cfg_sel (io.reg_cfg_sel_i),
        .ctx_sel     (w_unpacked),
        .err         (w_unpack_err)
    );

    // Clamp only exists when the index width can encode more than N_CTX contexts
    if ((2 ** CTX_W) > N_CTX) begin : g_clamp
        assign w_n_ctx_clamped = (io.n_ctx_i > c_ctx_max) ? c_ctx_max : io.n_ctx_i;
    end else begin : g_noclamp
        assign w_n_ctx_clamped = io.n_ctx_i;
    end

    assign w_ctx_inc = r_ctx + CTX_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_shadow_nxt  = r_shadow;
        w_sel_nxt     = r_sel;
        w_ctx_nxt     = r_ctx;
        w_iter_nxt    = r_iter;
        w_n_ctx_nxt   = r_n_ctx;
        w_n_iter_nxt  = r_n_iter;
        w_done_nxt    = 1'b0;
        w_cfg_err_nxt = r_cfg_err;
        unique case (r_state)
            IDLE: begin
                if (io.start_i) begin
                    w_state_nxt   = LOAD;
                    w_shadow_nxt  = w_unpacked;
                    w_cfg_err_nxt = w_unpack_err;
                    w_n_ctx_nxt   = w_n_ctx_clamped;
                    w_n_iter_nxt  = io.n_iter_i;
                end
            end
            LOAD: begin
                if (io.abort_i) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RUN;
                    w_sel_nxt   = r_shadow[0];
                    w_ctx_nxt   = '0;
                    w_iter_nxt  = '0;
                end
            end
            RUN: begin
                if (io.abort_i) begin
                    w_state_nxt = IDLE;
                end else if (io.step_i) begin
                    if (r_ctx < r_n_ctx) begin
                        w_ctx_nxt = w_ctx_inc;
                        w_sel_nxt = r_shadow[w_ctx_inc];
                    end else begin
                        w_ctx_nxt = '0;
                        // Final wrap ends the sequence; selectors keep the last context
                        if (r_iter == r_n_iter) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_iter_nxt = r_iter + 16'd1;
                            w_sel_nxt  = r_shadow[0];
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_shadow  <= '0;
            r_sel     <= '0;
            r_ctx     <= '0;
            r_iter    <= '0;
            r_n_ctx   <= '0;
            r_n_iter  <= '0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shadow  <= w_shadow_nxt;
            r_sel     <= w_sel_nxt;
            r_ctx     <= w_ctx_nxt;
            r_iter    <= w_iter_nxt;
            r_n_ctx   <= w_n_ctx_nxt;
            r_n_iter  <= w_n_iter_nxt;
            r_done    <= w_done_nxt;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    assign io.sel_output_o = r_sel;
    assign io.ctx_o        = r_ctx;
    assign io.busy_o       = (r_state != IDLE);
    assign io.done_o       = r_done;
    assign io.cfg_err_o    = r_cfg_err;

endmodule
`default_nettype wire
